// File: rtl/score_keeper_if.sv
// Score keeper signal bundle: ball/frame/button inputs and
// score, serve and game-state outputs.
interface score_keeper_if;
    logic [11:0] ball_center_col;
    logic        frame_tick;
    logic        start_btn;
    logic [7:0]  l_score;
    logic [7:0]  r_score;
    logic        ball_hold;
    logic        serve_dir;
    logic        point_pulse;
    logic        game_over;
    logic        winner;

    modport master (
        output ball_center_col, frame_tick, start_btn,
        input  l_score, r_score, ball_hold, serve_dir,
        input  point_pulse, game_over, winner
    );

    modport slave (
        input  ball_center_col, frame_tick, start_btn,
        output l_score, r_score, ball_hold, serve_dir,
        output point_pulse, game_over, winner
    );
endinterface

// File: rtl/score_keeper.sv
// Pong score keeper: miss detection, scoring, serve delay, game over.
// Define SCORE_BCD_EN for packed two-digit BCD scores.
module score_keeper #(
    parameter int DISP_COLS    = 800,
    parameter int L_MISS_COL   = 3,
    parameter int R_MISS_COL   = DISP_COLS - 3,
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60
) (
    input  logic          clk,
    input  logic          rst_n,
    score_keeper_if.slave sk
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        GAME_OVER
    } state_t;

    localparam logic [11:0] L_COL = 12'(L_MISS_COL);
    localparam logic [11:0] R_COL = 12'(R_MISS_COL);
    localparam logic [7:0]  SF    = 8'(SERVE_FRAMES);
`ifdef SCORE_BCD_EN
    localparam logic [7:0]  WIN_ENC =
        8'((WIN_SCORE / 10) * 16 + (WIN_SCORE % 10));
`else
    localparam logic [7:0]  WIN_ENC = 8'(WIN_SCORE);
`endif

    function automatic logic [7:0] inc(input logic [7:0] s);
`ifdef SCORE_BCD_EN
        if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        return s + 8'd1;
`else
        return s + 8'd1;
`endif
    endfunction

    state_t     state_q, state_d;
    logic [7:0] l_q, l_d, r_q, r_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       pulse_q, pulse_d;
    logic       win_q, win_d;
    logic       hold_q, over_q;
    logic       s1_q, s2_q, s3_q;
    logic       start_rise;
    logic       miss_l, miss_r;
    logic [7:0] l_inc, r_inc;

    // Raw button: two-flop synchroniser plus edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sk.start_btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign start_rise = s2_q & ~s3_q;
    assign miss_l     = sk.ball_center_col <= L_COL;
    assign miss_r     = sk.ball_center_col >= R_COL;
    assign l_inc      = inc(l_q);
    assign r_inc      = inc(r_q);

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        win_d   = win_q;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_rise) begin
                    l_d     = 8'd0;
                    r_d     = 8'd0;
                    dir_d   = 1'b1;
                    cnt_d   = SF;
                    state_d = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                if (sk.frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1)
                        state_d = PLAY;
                end
            end
            PLAY: begin
                if (miss_l) begin
                    r_d     = r_inc;
                    dir_d   = 1'b0;
                    pulse_d = 1'b1;
                    if (r_inc == WIN_ENC) begin
                        win_d   = 1'b1;
                        state_d = GAME_OVER;
                    end else begin
                        cnt_d   = SF;
                        state_d = SERVE_WAIT;
                    end
                end else if (miss_r) begin
                    l_d     = l_inc;
                    dir_d   = 1'b1;
                    pulse_d = 1'b1;
                    if (l_inc == WIN_ENC) begin
                        win_d   = 1'b0;
                        state_d = GAME_OVER;
                    end else begin
                        cnt_d   = SF;
                        state_d = SERVE_WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold and game_over follow the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= 8'd0;
            r_q     <= 8'd0;
            cnt_q   <= 8'd0;
            dir_q   <= 1'b1;
            pulse_q <= 1'b0;
            win_q   <= 1'b0;
            hold_q  <= 1'b1;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            win_q   <= win_d;
            hold_q  <= (state_d != PLAY);
            over_q  <= (state_d == GAME_OVER);
        end
    end

    assign sk.l_score     = l_q;
    assign sk.r_score     = r_q;
    assign sk.ball_hold   = hold_q;
    assign sk.serve_dir   = dir_q;
    assign sk.point_pulse = pulse_q;
    assign sk.game_over   = over_q;
    assign sk.winner      = win_q;

endmodule
